multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style sequencing FSM for the multicycle MIPS datapath. It decodes `Op`/`Funct`, samples `Zero`, and drives every datapath control strobe, including PC/IR/register-file/memory write enables, mux selects and `ALUControl`. It sits beside the datapath in the CPU top level and is the only source of its control inputs. One instruction executes per 3–5 cycles.

## Interface
Parameters:
- none; all encodings are constants in `multicycle_pkg`.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Op`  in  6  Instr[31:26] from datapath
- `Funct`  in  6  Instr[5:0] from datapath
- `Zero`  in  1  ALUResult == 0, live combinational
- `PCWrite`  out  1  PC register enable
- `PCSrc`  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- `RegWrite`  out  1  register-file write
- `IorD`  out  1  memory address: 0 PC, 1 ALUOut
- `MemWrite`  out  1  memory write
- `IRWrite`  out  1  instruction register enable
- `RegDst`  out  1  write reg: 0 rt, 1 rd
- `MemtoReg`  out  1  WD3: 0 ALUOut, 1 Data
- `ALUSrcA`  out  1  0 PC, 1 A
- `ALUSrcB`  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
- `ALUControl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- `gpio_i`  out  1  1 selects the sign-extended switches as SignImm
- `state_o`  out  4  current state code, for debug and the bench
- `instr_done_o`  out  1  one-cycle pulse in the final state of each instruction
- `illegal_o`  out  1  one-cycle pulse in DECODE on an unsupported Op/Funct

## Operation
States and their actions. Unlisted outputs are 0; `ALUControl` defaults to add.
- IDLE: all enables 0. Always goes to FETCH. Entered only from reset.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, PCSrc=00, PCWrite=1. Goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11 (branch target into ALUOut). Next state by Op:
  - lw 100011 / sw 101011 → MEMADR
  - R-type 000000 with legal funct → EXECUTE
  - addi 001000 → ADDIEX
  - swaddi 111111 → GPIOEX
  - beq 000100 → BRANCH
  - j 000010 → JUMP
  - anything else → FETCH with illegal_o=1
- MEMADR: ALUSrcA=1, ALUSrcB=10. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, done. Goes to FETCH.
- MEMWR: IorD=1, MemWrite=1, done. Goes to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from funct. Goes to ALUWB.
  - add 100000, sub 100010, and 100100, or 100101, slt 101010.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, done. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Goes to IMMWB.
- GPIOEX: as ADDIEX plus gpio_i=1. Goes to IMMWB.
- IMMWB: RegDst=0, MemtoReg=0, RegWrite=1, done. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWrite=Zero, done. Goes to FETCH.
- JUMP: PCSrc=10, PCWrite=1, done. Goes to FETCH.

Rules:
- All outputs decode from the registered state. The single exception is PCWrite in BRANCH, which is combinational on Zero.
- The state register alone is clocked; there is no other internal storage.

## Timing
- While reset is low, state=IDLE and every output is 0, except `state_o`=IDLE code 0 and ALUControl=010.
- After reset deasserts: 1 IDLE cycle, then FETCH.
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R-type 4, addi/swaddi 4, beq 3, j 3, illegal 2.
- `instr_done_o` rises in the final cycle; the next cycle is FETCH.
- BRANCH: PC updates at the end of the BRANCH cycle only if Zero is high in that cycle. Zero is not registered.
- Reset asserted mid-instruction returns the FSM to IDLE immediately and asynchronously. No partial write strobe persists past the edge.

## Configuration
- `BNE_EN` defined: Op 000101 is legal and goes to BRANCH with PCWrite=!Zero. This needs one internal flag latched in DECODE.
- `BNE_EN` undefined: 000101 is illegal and the flag is absent.

## Structure
- `multicycle_pkg` holds:
  - state enum: 4-bit codes, IDLE=0
  - opcode and funct localparams
  - ALUControl codes
  - ALUSrcB / PCSrc select codes
- Sub-module `alu_decoder`: combinational funct → {ALUControl, legal}. DECODE uses `legal`; EXECUTE uses `ALUControl`.

## Test plan
- Reset low 3 cycles, then high → all enables 0 during reset; IDLE for 1 cycle; FETCH asserts PCWrite=1, IRWrite=1, ALUSrcB=01.
- Op=100011 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; MemtoReg=1 and RegWrite=1 only in cycle 5; instr_done_o high in cycle 5 only.
- Op=000000, Funct=101010 → ALUControl=111 in EXECUTE; RegDst=1 and RegWrite=1 in ALUWB. Repeat with Funct=000000 → illegal_o in cycle 2, FETCH in cycle 3, no RegWrite.
- beq with Zero=1, then with Zero=0 in BRANCH → PCWrite=1 with PCSrc=01, then PCWrite=0; 3 cycles each.
- Op=111111 → gpio_i=1 only in GPIOEX, with ALUSrcB=10. Op=000010 → PCSrc=10 and PCWrite=1 in cycle 3.
- Reset asserted during MEMWR → MemWrite drops asynchronously, state_o=0. With `BNE_EN`, Op=000101 and Zero=0 → PCWrite=1.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes, opcodes,
// funct codes, ALU operations and datapath mux selects.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_GPIOEX  = 4'd10,
    S_IMMWB   = 4'd11,
    S_BRANCH  = 4'd12,
    S_JUMP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SWADDI = 6'b111111;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_J      = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder: yields the ALU operation and whether the
// funct is one the control unit supports.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_legal
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_legal       = 1'b1;
    case (i_funct)
      FUNCT_ADD: o_alu_control = ALU_ADD;
      FUNCT_SUB: o_alu_control = ALU_SUB;
      FUNCT_AND: o_alu_control = ALU_AND;
      FUNCT_OR:  o_alu_control = ALU_OR;
      FUNCT_SLT: o_alu_control = ALU_SLT;
      default:   o_legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multicycle MIPS datapath. Optional macro BNE_EN
// adds bne, reusing the BRANCH state with an inverted Zero test.
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       RegWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       gpio_i,
  output logic [3:0] state_o,
  output logic       instr_done_o,
  output logic       illegal_o
);

  state_t     r_state;
  logic [2:0] w_funct_alu;
  logic       w_funct_legal;
  logic       w_op_legal;

  alu_decoder u_alu_decoder (
    .i_funct       (Funct),
    .o_alu_control (w_funct_alu),
    .o_legal       (w_funct_legal)
  );

  always_comb begin
    w_op_legal = 1'b0;
    case (Op)
      OP_LW, OP_SW, OP_ADDI, OP_SWADDI, OP_BEQ, OP_J: w_op_legal = 1'b1;
      OP_RTYPE: w_op_legal = w_funct_legal;
`ifdef BNE_EN
      OP_BNE:   w_op_legal = 1'b1;
`endif
      default:  w_op_legal = 1'b0;
    endcase
  end

`ifdef BNE_EN
  logic r_bne;

  // Remembers whether the branch in flight is bne so BRANCH can invert Zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_bne <= 1'b0;
    else if (r_state == S_DECODE)
      r_bne <= (Op == OP_BNE);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          if (!w_op_legal)
            r_state <= S_FETCH;
          else if (is_mem_op(Op))
            r_state <= S_MEMADR;
          else begin
            case (Op)
              OP_RTYPE:  r_state <= S_EXECUTE;
              OP_ADDI:   r_state <= S_ADDIEX;
              OP_SWADDI: r_state <= S_GPIOEX;
              OP_BEQ:    r_state <= S_BRANCH;
`ifdef BNE_EN
              OP_BNE:    r_state <= S_BRANCH;
`endif
              OP_J:      r_state <= S_JUMP;
              default:   r_state <= S_FETCH;
            endcase
          end
        end
        S_MEMADR:  r_state <= (Op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   r_state <= S_MEMWB;
        S_EXECUTE: r_state <= S_ALUWB;
        S_ADDIEX:  r_state <= S_IMMWB;
        S_GPIOEX:  r_state <= S_IMMWB;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode is purely from the state register, except the branch PC
  // enable which must follow the live Zero flag within the BRANCH cycle.
  always_comb begin
    PCWrite      = 1'b0;
    PCSrc        = PCSRC_ALU;
    RegWrite     = 1'b0;
    IorD         = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_B;
    ALUControl   = ALU_ADD;
    gpio_i       = 1'b0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        PCSrc   = PCSRC_ALU;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB   = SRCB_IMMSH;
        illegal_o = ~w_op_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg     = 1'b1;
        RegWrite     = 1'b1;
        instr_done_o = 1'b1;
      end
      S_MEMWR: begin
        IorD         = 1'b1;
        MemWrite     = 1'b1;
        instr_done_o = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_B;
        ALUControl = w_funct_alu;
      end
      S_ALUWB: begin
        RegDst       = 1'b1;
        RegWrite     = 1'b1;
        instr_done_o = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_GPIOEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        gpio_i  = 1'b1;
      end
      S_IMMWB: begin
        RegWrite     = 1'b1;
        instr_done_o = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = SRCB_B;
        ALUControl   = ALU_SUB;
        PCSrc        = PCSRC_ALUOUT;
`ifdef BNE_EN
        PCWrite      = r_bne ? ~Zero : Zero;
`else
        PCWrite      = Zero;
`endif
        instr_done_o = 1'b1;
      end
      S_JUMP: begin
        PCSrc        = PCSRC_JUMP;
        PCWrite      = 1'b1;
        instr_done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, hand-written
// corner sequences, and random instructions against a per-instruction model.
module tb_multicycle_control;
  import multicycle_pkg::*;

  logic       clk, reset, Zero;
  logic [5:0] Op, Funct;
  logic       PCWrite, RegWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg;
  logic       ALUSrcA, gpio_i, instr_done_o, illegal_o;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .gpio_i(gpio_i),
    .state_o(state_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc; int nreg; int nmem; int npc; int ndone; int nill; int ngpio;
    int chk_alu; int alu;
  } exp_t;

  typedef struct {
    logic [5:0] op; logic [5:0] funct; logic z; exp_t e;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // Per-cycle observations of the most recent instruction (index = cycle-1).
  int         cyc_seen;
  logic [3:0] obs_state [12];
  logic [1:0] obs_srcb  [12];
  logic [1:0] obs_pcsrc [12];
  logic [11:0] reg_vec, mem_vec, pc_vec, done_vec, ill_vec, gpio_vec, m2r_vec, rd_vec;
  logic [2:0] alu_ex;
  logic       last_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic exp_t model(input logic [5:0] op, input logic [5:0] funct, input logic z);
    exp_t e;
    e = '{cyc: 2, nreg: 0, nmem: 0, npc: 1, ndone: 0, nill: 1, ngpio: 0, chk_alu: 0, alu: 2};
    if (op == 6'b100011) e = '{5, 1, 0, 1, 1, 0, 0, 0, 2};
    else if (op == 6'b101011) e = '{4, 0, 1, 1, 1, 0, 0, 0, 2};
    else if (op == 6'b001000) e = '{4, 1, 0, 1, 1, 0, 0, 0, 2};
    else if (op == 6'b111111) e = '{4, 1, 0, 1, 1, 0, 1, 0, 2};
    else if (op == 6'b000100) e = '{3, 0, 0, 1 + int'(z), 1, 0, 0, 0, 2};
    else if (op == 6'b000010) e = '{3, 0, 0, 2, 1, 0, 0, 0, 2};
`ifdef BNE_EN
    else if (op == 6'b000101) e = '{3, 0, 0, 1 + int'(!z), 1, 0, 0, 0, 2};
`endif
    else if (op == 6'b000000) begin
      case (funct)
        6'b100000: e = '{4, 1, 0, 1, 1, 0, 0, 1, 3'b010};
        6'b100010: e = '{4, 1, 0, 1, 1, 0, 0, 1, 3'b110};
        6'b100100: e = '{4, 1, 0, 1, 1, 0, 0, 1, 3'b000};
        6'b100101: e = '{4, 1, 0, 1, 1, 0, 0, 1, 3'b001};
        6'b101010: e = '{4, 1, 0, 1, 1, 0, 0, 1, 3'b111};
        default: ;
      endcase
    end
    return e;
  endfunction

  // Starts at a falling edge in FETCH; returns at the falling edge of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic z);
    Op = op; Funct = funct; Zero = z;
    cyc_seen = 0;
    reg_vec = '0; mem_vec = '0; pc_vec = '0; done_vec = '0; ill_vec = '0;
    gpio_vec = '0; m2r_vec = '0; rd_vec = '0; alu_ex = 3'b010; last_done = 1'b0;
    do begin
      #1;
      obs_state[cyc_seen] = state_o;
      obs_srcb[cyc_seen]  = ALUSrcB;
      obs_pcsrc[cyc_seen] = PCSrc;
      reg_vec[cyc_seen]  = RegWrite;
      mem_vec[cyc_seen]  = MemWrite;
      pc_vec[cyc_seen]   = PCWrite;
      done_vec[cyc_seen] = instr_done_o;
      ill_vec[cyc_seen]  = illegal_o;
      gpio_vec[cyc_seen] = gpio_i;
      m2r_vec[cyc_seen]  = MemtoReg;
      rd_vec[cyc_seen]   = RegDst;
      if (state_o == S_EXECUTE) alu_ex = ALUControl;
      last_done = instr_done_o;
      cyc_seen++;
      @(negedge clk);
    end while (state_o != S_FETCH && cyc_seen < 12);
  endtask

  task automatic check_instr(input string name, input vec_t v);
    run_instr(v.op, v.funct, v.z);
    chk({name, ".cycles"}, cyc_seen, v.e.cyc);
    chk({name, ".regwrite"}, $countones(reg_vec), v.e.nreg);
    chk({name, ".memwrite"}, $countones(mem_vec), v.e.nmem);
    chk({name, ".pcwrite"}, $countones(pc_vec), v.e.npc);
    chk({name, ".done"}, $countones(done_vec), v.e.ndone);
    chk({name, ".done_last"}, int'(last_done), v.e.ndone);
    chk({name, ".illegal"}, $countones(ill_vec), v.e.nill);
    chk({name, ".gpio"}, $countones(gpio_vec), v.e.ngpio);
    if (v.e.chk_alu != 0) chk({name, ".alu"}, int'(alu_ex), v.e.alu);
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] funct, input logic z,
                              input int cyc, nreg, nmem, npc, ndone, nill, ngpio, chk_alu, alu);
    vec_t v;
    v.op = op; v.funct = funct; v.z = z;
    v.e = '{cyc, nreg, nmem, npc, ndone, nill, ngpio, chk_alu, alu};
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    logic [5:0] rop, rfn;
    logic [5:0] legal_fn [5];
    vec_t rv;

    tbl[0]  = mk(6'b100011, 6'b000000, 1'b0, 5, 1, 0, 1, 1, 0, 0, 0, 2);
    tbl[1]  = mk(6'b101011, 6'b000000, 1'b0, 4, 0, 1, 1, 1, 0, 0, 0, 2);
    tbl[2]  = mk(6'b000000, 6'b100000, 1'b0, 4, 1, 0, 1, 1, 0, 0, 1, 3'b010);
    tbl[3]  = mk(6'b000000, 6'b100010, 1'b1, 4, 1, 0, 1, 1, 0, 0, 1, 3'b110);
    tbl[4]  = mk(6'b000000, 6'b100100, 1'b0, 4, 1, 0, 1, 1, 0, 0, 1, 3'b000);
    tbl[5]  = mk(6'b000000, 6'b100101, 1'b0, 4, 1, 0, 1, 1, 0, 0, 1, 3'b001);
    tbl[6]  = mk(6'b000000, 6'b101010, 1'b0, 4, 1, 0, 1, 1, 0, 0, 1, 3'b111);
    tbl[7]  = mk(6'b000000, 6'b000000, 1'b0, 2, 0, 0, 1, 0, 1, 0, 0, 2);
    tbl[8]  = mk(6'b001000, 6'b000000, 1'b0, 4, 1, 0, 1, 1, 0, 0, 0, 2);
    tbl[9]  = mk(6'b111111, 6'b000000, 1'b0, 4, 1, 0, 1, 1, 0, 1, 0, 2);
    tbl[10] = mk(6'b000100, 6'b000000, 1'b1, 3, 0, 0, 2, 1, 0, 0, 0, 2);
    tbl[11] = mk(6'b000100, 6'b000000, 1'b0, 3, 0, 0, 1, 1, 0, 0, 0, 2);
    tbl[12] = mk(6'b000010, 6'b000000, 1'b0, 3, 0, 0, 2, 1, 0, 0, 0, 2);
`ifdef BNE_EN
    tbl[13] = mk(6'b000101, 6'b000000, 1'b0, 3, 0, 0, 2, 1, 0, 0, 0, 2);
`else
    tbl[13] = mk(6'b000101, 6'b000000, 1'b0, 2, 0, 0, 1, 0, 1, 0, 0, 2);
`endif
    tbl[14] = mk(6'b001111, 6'b000000, 1'b0, 2, 0, 0, 1, 0, 1, 0, 0, 2);

    legal_fn[0] = 6'b100000; legal_fn[1] = 6'b100010; legal_fn[2] = 6'b100100;
    legal_fn[3] = 6'b100101; legal_fn[4] = 6'b101010;

    // Reset held low for three cycles
    reset = 1'b0; Op = 6'b100011; Funct = 6'b0; Zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset.state", int'(state_o), 0);
      chk("reset.enables", int'({PCWrite, IRWrite, RegWrite, MemWrite, instr_done_o, illegal_o}), 0);
      chk("reset.alucontrol", int'(ALUControl), 3'b010);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("release.idle", int'(state_o), int'(S_IDLE));
    chk("release.idle_irwrite", int'(IRWrite), 0);
    @(negedge clk);
    chk("fetch.state", int'(state_o), int'(S_FETCH));
    chk("fetch.pcwrite", int'(PCWrite), 1);
    chk("fetch.irwrite", int'(IRWrite), 1);
    chk("fetch.alusrcb", int'(ALUSrcB), 2'b01);
    chk("fetch.iord", int'(IorD), 0);

    for (int i = 0; i < 15; i++) check_instr($sformatf("tbl%0d", i), tbl[i]);

    // lw per-cycle sequence
    run_instr(6'b100011, 6'b0, 1'b0);
    chk("lw.s0", int'(obs_state[0]), int'(S_FETCH));
    chk("lw.s1", int'(obs_state[1]), int'(S_DECODE));
    chk("lw.s2", int'(obs_state[2]), int'(S_MEMADR));
    chk("lw.s3", int'(obs_state[3]), int'(S_MEMRD));
    chk("lw.s4", int'(obs_state[4]), int'(S_MEMWB));
    chk("lw.memtoreg_vec", int'(m2r_vec), 12'b10000);
    chk("lw.regwrite_vec", int'(reg_vec), 12'b10000);
    chk("lw.done_vec", int'(done_vec), 12'b10000);

    // slt: RegDst with RegWrite in ALUWB; funct 000000 is illegal
    run_instr(6'b000000, 6'b101010, 1'b0);
    chk("slt.regdst_vec", int'(rd_vec), 12'b1000);
    chk("slt.regwrite_vec", int'(reg_vec), 12'b1000);
    run_instr(6'b000000, 6'b000000, 1'b0);
    chk("rill.illegal_vec", int'(ill_vec), 12'b10);
    chk("rill.next_fetch", int'(state_o), int'(S_FETCH));

    // beq taken / not taken
    run_instr(6'b000100, 6'b0, 1'b1);
    chk("beq1.pc_vec", int'(pc_vec), 12'b101);
    chk("beq1.pcsrc", int'(obs_pcsrc[2]), 2'b01);
    run_instr(6'b000100, 6'b0, 1'b0);
    chk("beq0.pc_vec", int'(pc_vec), 12'b001);

    // swaddi and j
    run_instr(6'b111111, 6'b0, 1'b0);
    chk("swaddi.gpio_vec", int'(gpio_vec), 12'b0100);
    chk("swaddi.srcb", int'(obs_srcb[2]), 2'b10);
    run_instr(6'b000010, 6'b0, 1'b0);
    chk("j.pcsrc", int'(obs_pcsrc[2]), 2'b10);
    chk("j.pc_vec", int'(pc_vec), 12'b101);

    // Zero is live inside BRANCH
    Op = 6'b000100; Funct = 6'b0; Zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("branch_live.state", int'(state_o), int'(S_BRANCH));
    chk("branch_live.pc_z0", int'(PCWrite), 0);
    Zero = 1'b1;
    #1 chk("branch_live.pc_z1", int'(PCWrite), 1);
    @(negedge clk);
    chk("branch_live.next_fetch", int'(state_o), int'(S_FETCH));
    Zero = 1'b0;

    // Asynchronous reset during MEMWR
    Op = 6'b101011;
    repeat (3) @(negedge clk);
    #1;
    chk("sw_rst.memwr_state", int'(state_o), int'(S_MEMWR));
    chk("sw_rst.memwrite_before", int'(MemWrite), 1);
    #1 reset = 1'b0;
    #1;
    chk("sw_rst.memwrite_after", int'(MemWrite), 0);
    chk("sw_rst.state_after", int'(state_o), 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("sw_rst.idle", int'(state_o), int'(S_IDLE));
    @(negedge clk);
    chk("sw_rst.fetch", int'(state_o), int'(S_FETCH));

    // Random instructions against the model
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0: rop = 6'b100011;
        1: rop = 6'b101011;
        2: rop = 6'b000000;
        3: rop = 6'b001000;
        4: rop = 6'b111111;
        5: rop = 6'b000100;
        6: rop = 6'b000010;
        7: rop = 6'b000101;
        default: rop = 6'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0) rfn = legal_fn[$urandom_range(0, 4)];
      else rfn = 6'($urandom);
      rv.op = rop; rv.funct = rfn; rv.z = 1'($urandom);
      rv.e = model(rop, rfn, rv.z);
      check_instr($sformatf("rnd%0d_op%b_fn%b_z%0d", i, rop, rfn, rv.z), rv);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
